// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
//   slice_carry_t : lookahead summary produced by one cla_slice
//   calc_nblk()   : number of lookahead slices (= pipeline stages) per operand
// -----------------------------------------------------------------------------
package cla_pkg;

    // Group generate/propagate of a slice, its carry out, and the carry that
    // entered its most significant bit (needed for signed overflow).
    typedef struct packed {
        logic g;
        logic p;
        logic c_out;
        logic c_msb_in;
    } slice_carry_t;

    function automatic int calc_nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Purely combinational BLOCK-bit carry-lookahead adder slice.
// Ports:
//   a, b   : BLOCK-bit operands
//   cin    : carry into bit 0
//   sum    : BLOCK-bit sum
//   carry  : group G/P, carry out of the MSB, carry into the MSB
// -----------------------------------------------------------------------------
module cla_slice
    import cla_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output slice_carry_t     carry
);

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK:0]   c;     // c[i] = carry into bit i

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is expanded directly from the bit G/P terms and cin
    // (c[i+1] = G[i:0] | P[i:0] & cin) instead of rippling c[i] -> c[i+1].
    // After the last iteration acc/run hold the group G/P of the whole slice.
    always_comb begin
        logic acc;
        logic run;
        acc   = 1'b0;
        run   = 1'b1;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < BLOCK; i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (run & gen[j]);
                run = run & prop[j];
            end
            c[i+1] = acc | (run & cin);
        end
        sum            = prop ^ c[BLOCK-1:0];
        carry.g        = acc;
        carry.p        = run;
        carry.c_out    = c[BLOCK];
        carry.c_msb_in = c[BLOCK-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
// Pipelined carry-lookahead adder/subtractor. One BLOCK-bit lookahead slice is
// resolved per stage; a beat accepted at edge t is presented after edge
// t+NBLK. Throughput is one operation per cycle; the whole pipe freezes while
// a valid result waits for out_ready.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready = no output stall)
//   a, b, cin, sub        : operands; sub=1 gives a-b (cin ignored)
//   out_valid / out_ready : result handshake
//   s, carry_out          : result and carry (for sub, 1 = no borrow)
//   overflow, zero        : signed overflow, s == 0
// -----------------------------------------------------------------------------
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NBLK = calc_nblk(WIDTH, BLOCK);

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK");
    end
    if (BLOCK < 2 || BLOCK > 16) begin : g_bad_block
        $error("pipelined_cla_addsub: BLOCK must be in 2..16");
    end

    // Rank k holds the beat waiting for slice k: its valid bit, the carry into
    // slice k, the operands (only slices >= k still matter) and the result
    // slices < k already computed. Rank 0 is the entry register.
    logic             vld_reg [NBLK];
    logic             cy_reg  [NBLK];
    logic [WIDTH-1:0] opa_reg [NBLK];
    logic [WIDTH-1:0] opb_reg [NBLK];
    logic [WIDTH-1:0] res_reg [NBLK];

    logic             out_valid_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             stall;

    // Only a valid, unaccepted result stalls; an output bubble never does.
    assign stall     = out_valid_reg && !out_ready;
    assign in_ready  = !stall;

    assign out_valid = out_valid_reg;
    assign s         = s_reg;
    assign carry_out = carry_reg;
    assign overflow  = ovf_reg;
    assign zero      = zero_reg;

    // Entry: subtraction is a + ~b + 1, so precondition b and the carry here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_reg[0] <= 1'b0;
            cy_reg[0]  <= 1'b0;
            opa_reg[0] <= '0;
            opb_reg[0] <= '0;
            res_reg[0] <= '0;
        end else if (!stall) begin
            vld_reg[0] <= in_valid;
            cy_reg[0]  <= sub | cin;
            opa_reg[0] <= a;
            opb_reg[0] <= sub ? ~b : b;
            res_reg[0] <= '0;
        end
    end

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_stage
        localparam int LO = gi * BLOCK;

        logic [BLOCK-1:0] slice_sum;
        slice_carry_t     slice_cy;
        logic [WIDTH-1:0] res_next;

        cla_slice #(.BLOCK(BLOCK)) u_slice (
            .a     (opa_reg[gi][LO +: BLOCK]),
            .b     (opb_reg[gi][LO +: BLOCK]),
            .cin   (cy_reg[gi]),
            .sum   (slice_sum),
            .carry (slice_cy)
        );

        always_comb begin
            res_next = res_reg[gi];
            res_next[LO +: BLOCK] = slice_sum;
        end

        if (gi < NBLK - 1) begin : g_mid
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    vld_reg[gi+1] <= 1'b0;
                    cy_reg[gi+1]  <= 1'b0;
                    opa_reg[gi+1] <= '0;
                    opb_reg[gi+1] <= '0;
                    res_reg[gi+1] <= '0;
                end else if (!stall) begin
                    vld_reg[gi+1] <= vld_reg[gi];
                    cy_reg[gi+1]  <= slice_cy.c_out;
                    opa_reg[gi+1] <= opa_reg[gi];
                    opb_reg[gi+1] <= opb_reg[gi];
                    res_reg[gi+1] <= res_next;
                end
            end
        end else begin : g_last
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid_reg <= 1'b0;
                    s_reg         <= '0;
                    carry_reg     <= 1'b0;
                    ovf_reg       <= 1'b0;
                    zero_reg      <= 1'b0;
                end else if (!stall) begin
                    out_valid_reg <= vld_reg[gi];
                    // Flags only move with a real result so they hold
                    // their last value across bubbles.
                    if (vld_reg[gi]) begin
                        s_reg     <= res_next;
                        carry_reg <= slice_cy.c_out;
                        ovf_reg   <= slice_cy.c_out ^ slice_cy.c_msb_in;
                        zero_reg  <= ~|res_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

    localparam int NBLK = 4;   // 32 / 8

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1, carry_out, overflow, zero;
    logic [31:0] a = '0, b = '0, s;

    logic        v16 = 1'b0, ir16, ov16, co16, of16, z16;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        v8 = 1'b0, ir8, ov8, co8, of8, z8;
    logic [7:0]  a8 = '0, b8 = '0, s8;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] s;
        logic        co, ov, z;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(v16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(1'b0), .sub(1'b0), .out_valid(ov16), .out_ready(1'b1),
        .s(s16), .carry_out(co16), .overflow(of16), .zero(z16)
    );

    pipelined_cla_addsub #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(ov8), .out_ready(1'b1),
        .s(s8), .carry_out(co8), .overflow(of8), .zero(z8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [31:0] es, input logic eco,
                                input logic eov, input logic ez);
        exp_t e;
        e.name = nm; e.s = es; e.co = eco; e.ov = eov; e.z = ez; e.due = -1;
        return e;
    endfunction

    // Reference: plain 33-bit arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input string nm, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        logic [31:0] ye;
        logic [32:0] t;
        ye = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {32'd0, sb ? 1'b1 : ci};
        return mk(nm, t[31:0], t[32], (x[31] == ye[31]) && (t[31] != x[31]), t[31:0] == 32'd0);
    endfunction

    // One cycle of drive: inputs change at negedge, acceptance judged 1 time unit later.
    task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tc, input logic ts, input logic ordy,
                        input bit lat_chk, input exp_t e, output bit acc);
        exp_t ee;
        @(negedge clock);
        in_valid = v; a = ta; b = tbv; cin = tc; sub = ts; out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            ee = e;
            ee.due = lat_chk ? cyc + 1 + NBLK : -1;
            exp_q.push_back(ee);
            $display("issue  %s a=%h b=%h cin=%b sub=%b", e.name, ta, tbv, tc, ts);
        end
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b0, mk("idle", 32'd0, 1'b0, 1'b0, 1'b0), acc);
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                        input logic ts, input bit lat_chk, input exp_t e);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, ta, tbv, tc, ts, 1'b1, lat_chk, e, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++; n_errors++;
            $display("FAIL accept_%s: got in_ready=0 for %0d cycles want acceptance", e.name, tries);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor.
    exp_t        mon_e;
    logic [34:0] last_out = '0;
    bit          held = 1'b0;

    always @(negedge clock) begin
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_out: got out_valid=1 s=%h want no result", s);
            end else begin
                mon_e = exp_q[0];
                check({"result_", mon_e.name}, {29'd0, s, carry_out, overflow, zero},
                      {29'd0, mon_e.s, mon_e.co, mon_e.ov, mon_e.z});
                if (held)
                    check({"hold_", mon_e.name}, {29'd0, s, carry_out, overflow, zero}, {29'd0, last_out});
                else if (mon_e.due >= 0)
                    check({"latency_", mon_e.name}, 64'(cyc), 64'(mon_e.due));
                if (out_ready === 1'b1) begin
                    $display("result %s s=%h co=%b ov=%b z=%b", mon_e.name, s, carry_out, overflow, zero);
                    void'(exp_q.pop_front());
                end
            end
            last_out = {s, carry_out, overflow, zero};
        end
        held = (out_valid === 1'b1) && (out_ready === 1'b0);
    end

    // Single-beat test of the narrow instances (sel 0: 16/4, sel 1: 8/8).
    task automatic small_test(input string nm, input int sel, input logic [15:0] ta,
                              input logic [15:0] tbv, input logic [18:0] want, input int elat);
        int   t0;
        bit   got;
        logic [18:0] res;
        res = '0;
        @(negedge clock);
        if (sel == 0) begin v16 = 1'b1; a16 = ta; b16 = tbv; end
        else begin v8 = 1'b1; a8 = ta[7:0]; b8 = tbv[7:0]; end
        #1;
        t0 = cyc + 1;
        $display("issue  %s a=%h b=%h", nm, ta, tbv);
        @(negedge clock);
        v16 = 1'b0; v8 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            #1;
            if ((sel == 0) ? ov16 : ov8) begin
                got = 1'b1;
                res = (sel == 0) ? {s16, co16, of16, z16} : {8'd0, s8, co8, of8, z8};
                $display("result %s value=%h latency=%0d", nm, res, cyc - t0);
                check({"latency_", nm}, 64'(cyc - t0), 64'(elat));
                check({"result_", nm}, 64'(res), 64'(want));
            end else begin
                @(negedge clock);
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL timeout_%s: got no out_valid want one within 12 cycles", nm);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] x, y;
        logic        c, sb;
        logic [31:0] es;
        logic        eco, eov, ez;
    } vec_t;

    vec_t hv[8];
    bit   acc;
    int   idx;

    initial begin
        hv[0] = '{"add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        hv[1] = '{"sub_neg",   32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        hv[2] = '{"sub_zero",  32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        hv[3] = '{"sub_cin",   32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
        hv[4] = '{"add_wrap",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        hv[5] = '{"sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        hv[6] = '{"add_slice", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        hv[7] = '{"add_3slc",  32'h00FFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h01000001, 1'b0, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags", {29'd0, s, carry_out, overflow, zero}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Hand-computed vectors, back to back.
        for (int i = 0; i < 8; i++)
            send(hv[i].x, hv[i].y, hv[i].c, hv[i].sb, 1'b1,
                 mk(hv[i].nm, hv[i].es, hv[i].eco, hv[i].eov, hv[i].ez));
        drain();

        // 16-beat stream at full throughput.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x, y;
            x = 32'h9E3779B9 * (i + 1);
            y = 32'h7F4A7C15 ^ (32'h01010101 * i);
            step(1'b1, x, y, i[0], i[1], 1'b1, 1'b1,
                 model($sformatf("stream%0d", i), x, y, i[0], i[1]), acc);
            check($sformatf("stream_in_ready%0d", i), 64'(in_ready), 64'd1);
        end
        drain();

        // Back-pressure: out_ready low for 3 cycles once the pipe is full.
        idx = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            logic [31:0] x, y;
            logic        ordy;
            x = 32'hC0DE0000 + 32'h01111111 * idx;
            y = 32'h0F0F1234 * (idx + 3);
            ordy = !(c >= 6 && c < 9);
            step(1'b1, x, y, idx[0], idx[2], ordy, 1'b0,
                 model($sformatf("stall%0d", idx), x, y, idx[0], idx[2]), acc);
            if (!ordy) check($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            if (acc) idx++;
        end
        drain();

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 4; i++)
            send(32'h11111111 * (i + 1), 32'h01020304, 1'b0, 1'b0, 1'b1,
                 model($sformatf("doomed%0d", i), 32'h11111111 * (i + 1), 32'h01020304, 1'b0, 1'b0));
        idle(1'b0);
        #6;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_flags", {29'd0, s, carry_out, overflow, zero}, 64'd0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) idle(1'b1);
        send(32'h00001000, 32'h00000FFF, 1'b1, 1'b0, 1'b1,
             mk("post_rst", 32'h00002000, 1'b0, 1'b0, 1'b0));
        drain();

        // Narrow configurations.
        small_test("w16_wrap", 0, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0, 1'b1}, 4);
        small_test("w8_ovf",   1, 16'h0040, 16'h0040, {8'h00, 8'h80, 1'b0, 1'b1, 1'b0}, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
